// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Feeds the seven-segment display driver; bcd holds its value between done pulses.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; done cycle is also an IDLE cycle
// SHIFT | one add-3/shift iteration per clock, cnt iterations remaining
module bin2bcd_seq #(
  parameter int WIDTH  = 13,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int TW = BW + WIDTH;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic [BW-1:0]   acc, acc_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            busy_nxt, done_nxt;
  logic [BW-1:0]   bcd_nxt;
  logic [BW-1:0]   adj;
  logic [TW-1:0]   shifted;

  // Add 3 to every digit >= 5; a nibble tops out at 4'hC so no carry crosses digits.
  always_comb begin
    adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  assign shifted = {adj, sr} << 1;

  // Next-state and datapath updates; done defaults low so it is a single-cycle pulse.
  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    bcd_nxt   = bcd;
    case (state)
      IDLE: begin
        if (start) begin
          sr_nxt    = bin;
          acc_nxt   = '0;
          cnt_nxt   = CW'(WIDTH);
          busy_nxt  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        acc_nxt = shifted[TW-1:WIDTH];
        sr_nxt  = shifted[WIDTH-1:0];
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          bcd_nxt   = shifted[TW-1:WIDTH];
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything including the held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      bcd   <= bcd_nxt;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [12:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;

  typedef struct {
    logic [15:0] bcd;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   done_cyc[$];
  int   cyc = 0;
  int   busy_run = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  bin2bcd_seq #(.WIDTH(13), .DIGITS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares each done pulse against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        done_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("bcd", int'(bcd), int'(e.bcd));
          check("latency", cyc - e.acc_cyc, 13);
          check("busy_len", busy_run, 13);
          check("busy_with_done", int'(busy), 0);
        end
        busy_run = 0;
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  // Issues a conversion on the next IDLE edge; leaves start high if hold is set.
  task automatic convert(input int v, input bit hold);
    exp_t e;
    wait_idle();
    start = 1'b1;
    bin   = 13'(v);
    e.bcd = ref_bcd(v);
    e.acc_cyc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_bcd", int'(bcd), 0);
    rst = 1'b0;
    @(negedge clk);

    // zero
    convert(0, 1'b0);
    drain();

    // all ones, then result must hold
    convert(8191, 1'b0);
    drain();
    repeat (20) @(negedge clk);
    check("bcd_hold", int'(bcd), 16'h8191);

    // back-to-back, each started in the done cycle
    done_cyc.delete();
    convert(1234, 1'b0);
    convert(5, 1'b0);
    convert(10, 1'b0);
    drain();
    check("done_count", done_cyc.size(), 3);
    if (done_cyc.size() == 3) begin
      check("spacing_1", done_cyc[1] - done_cyc[0], 14);
      check("spacing_2", done_cyc[2] - done_cyc[1], 14);
    end

    // starts during SHIFT are ignored
    done_cyc.delete();
    convert(4095, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1; bin = 13'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    start = 1'b1; bin = 13'd9;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (30) @(negedge clk);
    check("single_done", done_cyc.size(), 1);

    // asynchronous reset mid-conversion
    done_cyc.delete();
    convert(777, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_bcd", int'(bcd), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cyc.size(), 0);
    convert(999, 1'b0);
    drain();

    // sweep with start held high continuously
    for (int v = 0; v < 8192; v++) begin
      if (v < 300 || v >= 7900 || (v % 53) == 0) convert(v, 1'b1);
    end
    start = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
